// File: rtl/ldpe_bank_sequencer.sv
// Round-robin write sequencer for a shared bank of transparent latches (one LDPE per bit).
// Each write runs SETUP -> OPEN -> HOLD so D is stable around the G window; PRESET pulses PRE.
module ldpe_bank_sequencer #(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 8,
  parameter int OPEN_CYC = 2,
  localparam int IDW     = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] data,
  output logic [NREQ-1:0]       ack,
  input  logic                  pre_req,
  output logic                  pre_ack,
  output logic                  g,
  output logic                  ge,
  output logic                  pre,
  output logic [WIDTH-1:0]      d,
  output logic                  busy,
  output logic [IDW-1:0]        grant_id
);

  if (OPEN_CYC < 1 || OPEN_CYC > 255) begin : g_bad_open_cyc
    $error("ldpe_bank_sequencer: OPEN_CYC must be in 1..255");
  end

  typedef enum logic [2:0] {IDLE, PRESET, SETUP, OPEN, HOLD} state_t;

  state_t          state, state_nxt;
  logic [7:0]      cnt, cnt_nxt;
  logic [IDW-1:0]  rr, rr_nxt;
  logic [IDW-1:0]  gid_nxt, pick;
  logic            found;
  logic [WIDTH-1:0] d_nxt;
  logic [NREQ-1:0] ack_nxt;
  logic            g_nxt, ge_nxt, pre_nxt, pre_ack_nxt;
  int              idx;

  // First requesting index at or above rr, wrapping around
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr) + k) % NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = IDW'(idx);
      end
    end
  end

  // Next state and next registered outputs; every output is a flop loaded from here
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    rr_nxt      = rr;
    gid_nxt     = grant_id;
    d_nxt       = d;
    ack_nxt     = '0;
    g_nxt       = 1'b0;
    ge_nxt      = 1'b0;
    pre_nxt     = 1'b0;
    pre_ack_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (pre_req) begin
          state_nxt   = PRESET;
          pre_nxt     = 1'b1;
          pre_ack_nxt = 1'b1;
        end else if (found) begin
          state_nxt = SETUP;
          gid_nxt   = pick;
          d_nxt     = data[int'(pick)*WIDTH +: WIDTH];
          ge_nxt    = 1'b1;
        end
      end
      PRESET: state_nxt = IDLE;
      SETUP: begin
        state_nxt = OPEN;
        cnt_nxt   = 8'(OPEN_CYC - 1);
        g_nxt     = 1'b1;
        ge_nxt    = 1'b1;
      end
      OPEN: begin
        ge_nxt = 1'b1;
        if (cnt == 8'd0) begin
          state_nxt         = HOLD;
          ack_nxt[grant_id] = 1'b1;
        end else begin
          cnt_nxt = cnt - 8'd1;
          g_nxt   = 1'b1;
        end
      end
      HOLD: begin
        state_nxt = IDLE;
        rr_nxt    = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      rr       <= '0;
      grant_id <= '0;
      d        <= '0;
      ack      <= '0;
      g        <= 1'b0;
      ge       <= 1'b0;
      pre      <= 1'b0;
      pre_ack  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      rr       <= rr_nxt;
      grant_id <= gid_nxt;
      d        <= d_nxt;
      ack      <= ack_nxt;
      g        <= g_nxt;
      ge       <= ge_nxt;
      pre      <= pre_nxt;
      pre_ack  <= pre_ack_nxt;
      busy     <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_ldpe_bank_sequencer.sv
// Directed bench for ldpe_bank_sequencer: a default instance (OPEN_CYC=2) plus an OPEN_CYC=1 instance,
// with a behavioural latch bank driven by the default instance's G/GE/PRE/D.
module tb_ldpe_bank_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]  req = '0, ack;
  logic [31:0] data = '0;
  logic        pre_req = 1'b0, pre_ack, g, ge, pre, busy;
  logic [7:0]  d, bank;
  logic [1:0]  grant_id;

  logic [3:0]  req1 = '0, ack1;
  logic [31:0] data1 = '0;
  logic        pre_req1 = 1'b0, pre_ack1, g1, ge1, pre1, busy1;
  logic [7:0]  d1;
  logic [1:0]  grant_id1;

  int n_checks = 0;
  int n_fail = 0;
  int viol = 0;

  ldpe_bank_sequencer #(.NREQ(4), .WIDTH(8), .OPEN_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .data(data), .ack(ack),
    .pre_req(pre_req), .pre_ack(pre_ack), .g(g), .ge(ge), .pre(pre),
    .d(d), .busy(busy), .grant_id(grant_id)
  );

  ldpe_bank_sequencer #(.NREQ(4), .WIDTH(8), .OPEN_CYC(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req1), .data(data1), .ack(ack1),
    .pre_req(pre_req1), .pre_ack(pre_ack1), .g(g1), .ge(ge1), .pre(pre1),
    .d(d1), .busy(busy1), .grant_id(grant_id1)
  );

  // Behavioural LDPE bank: async preset wins, transparent while G and GE are high
  always_latch begin
    if (pre) bank <= 8'hFF;
    else if (g && ge) bank <= d;
  end

  // Output invariants watched on every falling edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (!$onehot0(ack) || ((|ack) && pre_ack) || (pre && g)) viol++;
      if (!$onehot0(ack1) || ((|ack1) && pre_ack1) || (pre1 && g1)) viol++;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({g, ge, pre, busy, pre_ack} !== 5'b0 || ack !== 4'b0 || d !== 8'h00 || grant_id !== 2'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_outputs: got g/ge/pre/busy/pre_ack=%b ack=%b d=%h gid=%0d, want all zero",
               {g, ge, pre, busy, pre_ack}, ack, d, grant_id);
    end
    @(posedge clk);
    #2 rst_n = 1'b1;
    tick;
    n_checks++;
    if ({busy, ge} !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL reset_idle: got busy/ge=%b want 00", {busy, ge});
    end
  endtask

  task automatic test_single_write;
    int gcount = 0;
    int ack_cyc = 0;
    logic [3:0] ack_seen = '0;
    bit d_bad = 0;
    data[7:0] = 8'hA5;
    req = 4'b0001;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      tick;
      if (g) gcount++;
      if (ack !== 4'b0 && ack_cyc == 0) begin
        ack_cyc = cyc;
        ack_seen = ack;
      end
      if (ge && d !== 8'hA5) d_bad = 1;
      if (cyc == 1) req = 4'b0000;
    end
    n_checks++;
    if (gcount != 2) begin
      n_fail++;
      $display("[TB] FAIL single_g_cycles: got %0d want 2", gcount);
    end
    n_checks++;
    if (ack_cyc != 4 || ack_seen !== 4'b0001) begin
      n_fail++;
      $display("[TB] FAIL single_ack: got cycle %0d ack=%b want cycle 4 ack=0001", ack_cyc, ack_seen);
    end
    n_checks++;
    if (d_bad || bank !== 8'hA5 || busy !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL single_data: d_bad=%0d bank=%h busy=%b want 0/a5/0", d_bad, bank, busy);
    end
  endtask

  task automatic test_round_robin;
    int exp_idx[5] = '{0, 1, 2, 3, 0};
    int got_idx[5];
    int got_at[5];
    int n = 0;
    do_reset;
    #1;
    data = 32'h44332211;
    req = 4'b1111;
    for (int cyc = 1; cyc <= 40 && n < 5; cyc++) begin
      tick;
      if (ack !== 4'b0) begin
        got_idx[n] = -1;
        for (int b = 0; b < 4; b++) if (ack[b]) got_idx[n] = b;
        got_at[n] = cyc;
        n++;
        if (n == 5) req = 4'b0000;
      end
    end
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if (k >= n || got_idx[k] != exp_idx[k] || got_at[k] != 4 + 5 * k) begin
        n_fail++;
        $display("[TB] FAIL rr_ack%0d: got idx %0d at cycle %0d want idx %0d at cycle %0d",
                 k, (k < n) ? got_idx[k] : -1, (k < n) ? got_at[k] : -1, exp_idx[k], 4 + 5 * k);
      end
    end
    tick;
    n_checks++;
    if (bank !== 8'h11) begin
      n_fail++;
      $display("[TB] FAIL rr_bank: got %h want 11", bank);
    end
  endtask

  task automatic test_preset_priority;
    bit got = 0;
    data[15:8] = 8'h5A;
    pre_req = 1'b1;
    req = 4'b0010;
    tick;
    n_checks++;
    if ({pre, pre_ack, g, ge, busy} !== 5'b11001 || bank !== 8'hFF) begin
      n_fail++;
      $display("[TB] FAIL preset_pulse: got pre/pre_ack/g/ge/busy=%b bank=%h want 11001 ff",
               {pre, pre_ack, g, ge, busy}, bank);
    end
    pre_req = 1'b0;
    tick;
    n_checks++;
    if ({pre, pre_ack, busy} !== 3'b000) begin
      n_fail++;
      $display("[TB] FAIL preset_end: got pre/pre_ack/busy=%b want 000", {pre, pre_ack, busy});
    end
    tick;
    n_checks++;
    if ({ge, grant_id} !== 3'b101) begin
      n_fail++;
      $display("[TB] FAIL preset_then_grant: got ge=%b gid=%0d want ge=1 gid=1", ge, grant_id);
    end
    for (int i = 0; i < 10 && !got; i++) begin
      tick;
      if (ack !== 4'b0) got = 1;
    end
    n_checks++;
    if (!got || ack !== 4'b0010) begin
      n_fail++;
      $display("[TB] FAIL preset_write_ack: got seen=%0d ack=%b want 0010", got, ack);
    end
    req = 4'b0000;
    tick;
    n_checks++;
    if (bank !== 8'h5A) begin
      n_fail++;
      $display("[TB] FAIL preset_write_bank: got %h want 5a", bank);
    end
  endtask

  task automatic test_reset_mid_open;
    bit got = 0;
    data[7:0] = 8'h3C;
    req = 4'b0001;
    tick;
    tick;
    n_checks++;
    if (g !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL midopen_g_before: got %b want 1", g);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({g, ge, busy, pre} !== 4'b0 || ack !== 4'b0 || grant_id !== 2'd0) begin
      n_fail++;
      $display("[TB] FAIL midopen_reset: got g/ge/busy/pre=%b ack=%b gid=%0d want 0000 0000 0",
               {g, ge, busy, pre}, ack, grant_id);
    end
    req = 4'b1000;
    data[31:24] = 8'hC3;
    #1 rst_n = 1'b1;
    tick;
    n_checks++;
    if ({ge, grant_id} !== 3'b111) begin
      n_fail++;
      $display("[TB] FAIL midopen_regrant: got ge=%b gid=%0d want ge=1 gid=3", ge, grant_id);
    end
    for (int i = 0; i < 10 && !got; i++) begin
      tick;
      if (ack !== 4'b0) got = 1;
    end
    n_checks++;
    if (!got || ack !== 4'b1000) begin
      n_fail++;
      $display("[TB] FAIL midopen_ack: got seen=%0d ack=%b want 1000", got, ack);
    end
    req = 4'b0000;
    tick;
  endtask

  task automatic test_req_drop;
    bit got = 0;
    data[23:16] = 8'h5C;
    req = 4'b0100;
    tick;
    n_checks++;
    if (d !== 8'h5C || grant_id !== 2'd2) begin
      n_fail++;
      $display("[TB] FAIL drop_grant: got d=%h gid=%0d want 5c gid=2", d, grant_id);
    end
    req = 4'b0000;
    data[23:16] = 8'h00;
    for (int i = 0; i < 10 && !got; i++) begin
      tick;
      if (ack !== 4'b0) got = 1;
    end
    n_checks++;
    if (!got || ack !== 4'b0100) begin
      n_fail++;
      $display("[TB] FAIL drop_ack: got seen=%0d ack=%b want 0100", got, ack);
    end
    tick;
    n_checks++;
    if (d !== 8'h5C || bank !== 8'h5C) begin
      n_fail++;
      $display("[TB] FAIL drop_data: got d=%h bank=%h want 5c 5c", d, bank);
    end
  endtask

  task automatic test_open_cyc1;
    int gcount = 0;
    int ack_at[2] = '{0, 0};
    int n = 0;
    data1[7:0] = 8'h77;
    req1 = 4'b0001;
    for (int cyc = 1; cyc <= 12 && n < 2; cyc++) begin
      tick;
      if (g1 && n == 0) gcount++;
      if (ack1 !== 4'b0) begin
        ack_at[n] = cyc;
        n++;
        if (n == 2) req1 = 4'b0000;
      end
    end
    n_checks++;
    if (gcount != 1) begin
      n_fail++;
      $display("[TB] FAIL oc1_g_cycles: got %0d want 1", gcount);
    end
    n_checks++;
    if (ack_at[0] != 3 || ack_at[1] != 7) begin
      n_fail++;
      $display("[TB] FAIL oc1_ack_timing: got cycles %0d,%0d want 3,7", ack_at[0], ack_at[1]);
    end
    tick;
    tick;
  endtask

  task automatic test_invariants;
    n_checks++;
    if (viol != 0) begin
      n_fail++;
      $display("[TB] FAIL invariants: got %0d violating cycles want 0", viol);
    end
  endtask

  initial begin
    test_reset;
    test_single_write;
    test_round_robin;
    test_preset_priority;
    test_reset_mid_open;
    test_req_drop;
    test_open_cyc1;
    test_invariants;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
